// File: rtl/m2m_xfer_ctrl_if.sv
// rtl/m2m_xfer_ctrl_if.sv - strobe/status bundle between m2m_xfer_ctrl and its datapath
//
// Groups every non-clock, non-reset signal of the transfer controller.
//   master : the controller (samples Start/AddrA/AddrB/Keep, drives strobes and status)
//   slave  : the datapath / environment (drives Start/AddrA/AddrB/Keep)
// Signals:
//   Start  - begin a run (only honoured in IDLE)
//   AddrA  - counter A address, AW_A bits
//   AddrB  - counter B address, AW_B bits
//   Keep   - comparator result for the current memory A word
//   IncA   - increment counter A      IncB - increment counter B
//   WEA    - write memory A           WEB  - write memory B
//   CntRst - synchronous clear of both counters
//   ClrB   - force zero onto memory B write data
//   Busy   - run in progress          Done - one-cycle completion pulse

interface m2m_xfer_ctrl_if #(
    parameter int AW_A = 3,
    parameter int AW_B = 2
);
    logic            Start;
    logic [AW_A-1:0] AddrA;
    logic [AW_B-1:0] AddrB;
    logic            Keep;
    logic            IncA;
    logic            IncB;
    logic            WEA;
    logic            WEB;
    logic            CntRst;
    logic            ClrB;
    logic            Busy;
    logic            Done;

    modport master (
        input  Start, AddrA, AddrB, Keep,
        output IncA, IncB, WEA, WEB, CntRst, ClrB, Busy, Done
    );

    modport slave (
        output Start, AddrA, AddrB, Keep,
        input  IncA, IncB, WEA, WEB, CntRst, ClrB, Busy, Done
    );
endinterface

// File: rtl/m2m_xfer_ctrl.sv
// rtl/m2m_xfer_ctrl.sv - fill/transfer sequencing controller for the memory-to-memory datapath
//
// Fills memory A sequentially, optionally zeroes memory B, then copies every
// memory A word flagged by Keep into consecutive memory B locations. One run
// per Start pulse; Done pulses for one cycle at the end of the run.
//
// Optional feature: define M2M_CLEARB_EN to include the CLRB phase that
// zeroes memory B before each transfer. Without it ClrB is tied low.
//
// Ports:
//   clock - rising-edge clock
//   Reset - asynchronous, active-high reset (state returns to IDLE at once)
//   bus   - m2m_xfer_ctrl_if.master: Start/AddrA/AddrB/Keep in,
//           IncA/IncB/WEA/WEB/CntRst/ClrB/Busy/Done out

module m2m_xfer_ctrl #(
    parameter int AW_A = 3,
    parameter int AW_B = 2
) (
    input  logic               clock,
    input  logic               Reset,
    m2m_xfer_ctrl_if.master    bus
);

    // Terminal counts of the two address counters.
    localparam logic [AW_A-1:0] LAST_A = '1;
    localparam logic [AW_B-1:0] LAST_B = '1;

`ifdef M2M_CLEARB_EN
    typedef enum logic [2:0] {IDLE, FILL, CLRB, XFER, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FILL, XFER, DONE} state_t;
`endif

    state_t state;
    state_t state_nxt;

    logic inc_a;
    logic inc_b;
    logic we_a;
    logic we_b;
    logic cnt_rst;
    logic clr_b;
    logic busy;
    logic done;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode the registered state; Keep is the only input that
    // reaches an output combinationally (WEB/IncB during XFER).
    always_comb begin
        state_nxt = state;
        inc_a     = 1'b0;
        inc_b     = 1'b0;
        we_a      = 1'b0;
        we_b      = 1'b0;
        cnt_rst   = 1'b0;
        clr_b     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.Start) begin
                    state_nxt = FILL;
                end
            end

            FILL: begin
                we_a  = 1'b1;
                inc_a = 1'b1;
                busy  = 1'b1;
                // Counter A wraps to 0 on this edge, so XFER starts at word 0.
                if (bus.AddrA == LAST_A) begin
`ifdef M2M_CLEARB_EN
                    state_nxt = CLRB;
`else
                    state_nxt = XFER;
`endif
                end
            end

`ifdef M2M_CLEARB_EN
            CLRB: begin
                we_b  = 1'b1;
                inc_b = 1'b1;
                clr_b = 1'b1;
                busy  = 1'b1;
                // Counter B wraps to 0 here, leaving it ready for the copy.
                if (bus.AddrB == LAST_B) begin
                    state_nxt = XFER;
                end
            end
`endif

            XFER: begin
                inc_a = 1'b1;
                busy  = 1'b1;
                we_b  = bus.Keep;
                inc_b = bus.Keep;
                // Stop when the source is exhausted or this write fills B;
                // the last write/increment still happens on this edge.
                if ((bus.AddrA == LAST_A) || (bus.Keep && (bus.AddrB == LAST_B))) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                done      = 1'b1;
                cnt_rst   = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.IncA   = inc_a;
    assign bus.IncB   = inc_b;
    assign bus.WEA    = we_a;
    assign bus.WEB    = we_b;
    assign bus.CntRst = cnt_rst;
    assign bus.ClrB   = clr_b;
    assign bus.Busy   = busy;
    assign bus.Done   = done;

endmodule

// File: tb/tb_m2m_xfer_ctrl.sv
// tb/tb_m2m_xfer_ctrl.sv - self-checking bench for m2m_xfer_ctrl with a behavioural datapath

module tb_m2m_xfer_ctrl;

    localparam int AW_A = 3;
    localparam int AW_B = 2;
    localparam int DA   = 8;
    localparam int DB   = 4;
`ifdef M2M_CLEARB_EN
    localparam int NCLR = DB;
`else
    localparam int NCLR = 0;
`endif

    logic clock = 1'b0;
    logic Reset = 1'b1;
    always #5 clock = ~clock;

    m2m_xfer_ctrl_if #(.AW_A(AW_A), .AW_B(AW_B)) bus();

    m2m_xfer_ctrl #(.AW_A(AW_A), .AW_B(AW_B)) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] mem_a [DA];
    logic [7:0] mem_b [DB];
    logic [7:0] fill  [DA];
    logic [7:0] exp_b [DB];

    logic [7:0] obs [1:24];
    int         nobs;
    logic [4:0] addr_after;

    // Datapath: two address counters plus the two memories.
    always @(posedge clock or posedge Reset) begin
        if (Reset) begin
            bus.AddrA <= '0;
            bus.AddrB <= '0;
        end else if (bus.CntRst) begin
            bus.AddrA <= '0;
            bus.AddrB <= '0;
        end else begin
            if (bus.IncA) bus.AddrA <= bus.AddrA + 1'b1;
            if (bus.IncB) bus.AddrB <= bus.AddrB + 1'b1;
        end
    end

    always @(posedge clock) begin
        if (bus.WEA) mem_a[bus.AddrA] <= fill[bus.AddrA];
    end

    always @(posedge clock or posedge Reset) begin
        if (Reset) begin
            for (int j = 0; j < DB; j++) mem_b[j] <= 8'h00;
        end else if (bus.WEB) begin
            mem_b[bus.AddrB] <= bus.ClrB ? 8'h00 : mem_a[bus.AddrA];
        end
    end

    // Number of XFER cycles: all of A, unless the DB-th kept word fills B first.
    function automatic int xfer_len(input logic [7:0] kp);
        int cnt;
        cnt = 0;
        for (int x = 0; x < DA; x++) begin
            if (kp[x]) cnt++;
            if (cnt == DB) return x + 1;
        end
        return DA;
    endfunction

    // Expected {IncA,IncB,WEA,WEB,CntRst,ClrB,Busy,Done} in cycle c after the Start edge.
    function automatic logic [7:0] exp_vec(input int c, input logic [7:0] kp);
        int nx;
        int x;
        nx = xfer_len(kp);
        x  = c - DA - NCLR - 1;
        if (c <= DA)             return 8'b1010_0010;
        else if (c <= DA + NCLR) return 8'b0101_0110;
        else if (x < nx)         return {1'b1, kp[x], 1'b0, kp[x], 4'b0010};
        else if (x == nx)        return 8'b0000_1001;
        else                     return 8'b0000_0000;
    endfunction

    // Memory B contents expected after a run with keep pattern kp.
    task automatic model_b(input logic [7:0] kp);
        int nx;
        int j;
        nx = xfer_len(kp);
`ifdef M2M_CLEARB_EN
        for (int k = 0; k < DB; k++) exp_b[k] = 8'h00;
`endif
        j = 0;
        for (int x = 0; x < nx; x++) begin
            if (kp[x]) begin
                exp_b[j] = fill[x];
                j++;
            end
        end
    endtask

    // Issues Start (from the current IDLE cycle) and records every output
    // through the cycle after Done. Keep is randomised outside XFER.
    task automatic run_xfer(input logic [7:0] kp);
        int nx;
        nx   = xfer_len(kp);
        nobs = DA + NCLR + nx + 2;
        for (int i = 0; i < DA; i++) fill[i] = 8'($urandom);
        bus.Start = 1'b1;
        for (int c = 1; c <= nobs; c++) begin
            @(posedge clock);
            #1;
            bus.Start = 1'b0;
            if (c > DA + NCLR && c <= DA + NCLR + nx) bus.Keep = kp[c - DA - NCLR - 1];
            else                                     bus.Keep = 1'($urandom);
            @(negedge clock);
            obs[c] = {bus.IncA, bus.IncB, bus.WEA, bus.WEB, bus.CntRst, bus.ClrB, bus.Busy, bus.Done};
            if (c == nobs) addr_after = {bus.AddrA, bus.AddrB};
        end
        bus.Keep = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < DB; k++) exp_b[k] = 8'h00;
        bus.Start = 1'b0;
        bus.Keep  = 1'b0;
        Reset     = 1'b1;
        repeat (2) @(negedge clock);
        tests++;
        if ({bus.IncA, bus.IncB, bus.WEA, bus.WEB, bus.CntRst, bus.ClrB, bus.Busy, bus.Done} !== 8'h00) begin
            fails++;
            $display("FAIL reset_in_reset: outputs=%b want 00000000",
                     {bus.IncA, bus.IncB, bus.WEA, bus.WEB, bus.CntRst, bus.ClrB, bus.Busy, bus.Done});
        end
        Reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            tests++;
            if ({bus.IncA, bus.IncB, bus.WEA, bus.WEB, bus.CntRst, bus.ClrB, bus.Busy, bus.Done,
                 bus.AddrA, bus.AddrB} !== 13'h0) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: outputs=%b addr=%0d/%0d want all 0", c,
                         {bus.IncA, bus.IncB, bus.WEA, bus.WEB, bus.CntRst, bus.ClrB, bus.Busy, bus.Done},
                         bus.AddrA, bus.AddrB);
            end
        end
    endtask

    // Directed keep patterns: none, cycles 0/2/5, and always (early B-full).
    task automatic test_keep_patterns();
        logic [7:0] pats [3];
        pats[0] = 8'h00;
        pats[1] = 8'h25;
        pats[2] = 8'hFF;
        for (int p = 0; p < 3; p++) begin
            run_xfer(pats[p]);
            model_b(pats[p]);
            for (int c = 1; c <= nobs; c++) begin
                tests++;
                if (obs[c] !== exp_vec(c, pats[p])) begin
                    fails++;
                    $display("FAIL keep_pat %h cycle %0d: outputs=%b want %b", pats[p], c, obs[c], exp_vec(c, pats[p]));
                end
            end
            tests++;
            if (addr_after !== 5'd0) begin
                fails++;
                $display("FAIL keep_pat %h counters_after_done: addr=%h want 00", pats[p], addr_after);
            end
            for (int j = 0; j < DB; j++) begin
                tests++;
                if (mem_b[j] !== exp_b[j]) begin
                    fails++;
                    $display("FAIL keep_pat %h mem_b[%0d]: got %h want %h", pats[p], j, mem_b[j], exp_b[j]);
                end
            end
        end
    endtask

    // Random keep patterns, each Start raised in the IDLE cycle right after the previous Done.
    task automatic test_back_to_back();
        logic [7:0] kp;
        for (int r = 0; r < 8; r++) begin
            kp = 8'($urandom);
            run_xfer(kp);
            model_b(kp);
            for (int c = 1; c <= nobs; c++) begin
                tests++;
                if (obs[c] !== exp_vec(c, kp)) begin
                    fails++;
                    $display("FAIL b2b run %0d kp %h cycle %0d: outputs=%b want %b", r, kp, c, obs[c], exp_vec(c, kp));
                end
            end
            tests++;
            if (addr_after !== 5'd0) begin
                fails++;
                $display("FAIL b2b run %0d counters_after_done: addr=%h want 00", r, addr_after);
            end
            for (int j = 0; j < DB; j++) begin
                tests++;
                if (mem_b[j] !== exp_b[j]) begin
                    fails++;
                    $display("FAIL b2b run %0d mem_b[%0d]: got %h want %h", r, j, mem_b[j], exp_b[j]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        int seen_done;
        int done_at;
        bus.Keep  = 1'b0;
        bus.Start = 1'b1;
        @(posedge clock);
        #1 bus.Start = 1'b0;
        seen_done = 0;
        // Run to the XFER cycle where AddrA = 4.
        for (int c = 1; c <= DA + NCLR + 5; c++) begin
            @(negedge clock);
            if (bus.Done) seen_done = 1;
        end
        tests++;
        if ({bus.Busy, bus.IncA, bus.AddrA} !== {2'b11, 3'd4}) begin
            fails++;
            $display("FAIL midrun_position: busy=%b inca=%b addra=%0d want 1 1 4", bus.Busy, bus.IncA, bus.AddrA);
        end
        #2 Reset = 1'b1;
        #1;
        tests++;
        if ({bus.IncA, bus.IncB, bus.WEA, bus.WEB, bus.CntRst, bus.ClrB, bus.Busy, bus.Done, bus.AddrA} !== 11'h0) begin
            fails++;
            $display("FAIL midrun_reset_outputs: outputs=%b addra=%0d want all 0",
                     {bus.IncA, bus.IncB, bus.WEA, bus.WEB, bus.CntRst, bus.ClrB, bus.Busy, bus.Done}, bus.AddrA);
        end
        repeat (2) begin
            @(negedge clock);
            if (bus.Done) seen_done = 1;
        end
        tests++;
        if (seen_done !== 0) begin
            fails++;
            $display("FAIL midrun_no_done: done seen=%0d want 0", seen_done);
        end
        Reset     = 1'b0;
        bus.Start = 1'b1;
        @(posedge clock);
        #1 bus.Start = 1'b0;
        @(negedge clock);
        tests++;
        if ({bus.WEA, bus.IncA, bus.Busy} !== 3'b111) begin
            fails++;
            $display("FAIL restart_after_reset: wea/inca/busy=%b want 111", {bus.WEA, bus.IncA, bus.Busy});
        end
        done_at = 0;
        for (int c = 2; c <= DA + NCLR + DA + 3; c++) begin
            @(negedge clock);
            if (bus.Done && done_at == 0) done_at = c;
        end
        tests++;
        if (done_at !== DA + NCLR + DA + 1) begin
            fails++;
            $display("FAIL restart_done_cycle: got %0d want %0d", done_at, DA + NCLR + DA + 1);
        end
        for (int k = 0; k < DB; k++) exp_b[k] = 8'h00;
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.Keep  = 1'b0;
        test_reset();
        test_keep_patterns();
        test_back_to_back();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
